load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the word-organised data memory: accepts one RV32I load/store
//  per handshake, drives MemRead/MemWrite/addr/write_data, and returns sign/zero-extended
//  load data. Sub-word stores (SB/SH) use read-modify-write, since memory only writes words.
//  Sits between the execute stage and the data memory.
// PARAMETERS
//  ADDR_W  9   byte-address width; word index = addr[ADDR_W-1:2]
//  DATA_W  32  data word width; fixed at 32 (byte-lane logic assumes 4 lanes)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  req_valid   in   1       request present
//  req_ready   out  1       unit can accept; transfer when req_valid & req_ready
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data; low byte/half used for SB/SH
//  resp_valid  out  1       one-cycle pulse: operation complete
//  resp_rdata  out  32      load result; held until next response
//  resp_err    out  1       misaligned/illegal funct3; valid with resp_valid
//  MemRead     out  1       memory read enable
//  MemWrite    out  1       memory write enable
//  addr        out  ADDR_W  memory byte address, always word-aligned (addr[1:0]=00)
//  write_data  out  32      memory write word
//  read_data   in   32      memory read word, combinational from addr while MemRead=1
// BEHAVIOUR
//  Reset: state IDLE; req_ready=0 while rst=1; resp_valid, resp_err, MemRead, MemWrite=0;
//   resp_rdata, addr, write_data=0.
//  FSM: IDLE, RD, WR, RESP. req_ready=1 only in IDLE. Request fields latch on accept.
//  On accept: illegal funct3 (011,110,111; store with 100/101) or misaligned
//   (H/HU addr[0]=1; W addr[1:0]!=0) -> RESP with resp_err=1; no memory access.
//   Load -> RD. SW -> WR. SB/SH -> RD then WR.
//  RD: MemRead=1; addr={word idx,2'b00}; read_data registered at RD's closing edge.
//  WR: MemWrite=1 for exactly one cycle. write_data = req_wdata (SW) or the captured
//   word with the selected byte/half lane replaced (SB lane=addr[1:0]; SH lane=addr[1]).
//  RESP: resp_valid=1 for one cycle, then IDLE. Loads update resp_rdata: LB/LH
//   sign-extend, LBU/LHU zero-extend, LW whole word. Stores/errors leave resp_rdata unchanged.
//  Latency from accept edge to resp_valid: error +1, load/SW +2, SB/SH +3.
//   Next accept is no earlier than the cycle after RESP. No response backpressure.
//  MemRead/MemWrite/addr/write_data decode only from registered state and latched fields:
//   glitch-free and stable for the whole cycle (memory writes level-sensitively).
//   MemRead and MemWrite are never high together.
//  Reset mid-operation: abort immediately, MemWrite drops asynchronously, no response.
//   An RMW aborted in RD leaves memory unmodified.
//  Request inputs are ignored outside the accept cycle.
// STRUCTURE
//  Package lsu_pkg: funct3 constants (F3_B/H/W/BU/HU), state encoding, lane-select helpers.
//  Sub-module lsu_align (combinational): load extract+extend and store lane merge,
//   from funct3, addr[1:0], word and store data. FSM and registers stay in load_store_unit.
// TESTING (memory model 128x32, preloaded mem[i]=i, combinational read, level write)
//  LW addr 0x010 -> MemRead=1 one cycle at addr 0x010; resp_valid at +2, rdata 0x00000004.
//  SB 0x011 data 0x...AB -> RD then WR; mem[4]=0x0000AB04; then LB 0x011 ->
//   0xFFFFFFAB and LBU 0x011 -> 0x000000AB.
//  SH 0x00E data 0x8001 -> mem[3]=0x80010003; LH 0x00E -> 0xFFFF8001; LHU -> 0x00008001.
//  LW 0x006 and SH 0x021 -> resp_err=1 at +1; MemRead/MemWrite never high; memory unchanged.
//  Assert rst during RD of SB 0x021 -> no MemWrite, mem[8]=8, resp_valid stays 0;
//   after release, IDLE with req_ready=1.
//  req_valid held high over SW 0x040 then LW 0x040 -> second accepted only after RESP;
//   read returns the stored word; MemRead&MemWrite never coincide.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and lane helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] lane_half(input logic [31:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    // Stores have no unsigned forms; halves need even, words need 4-byte alignment.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = lo[0];
            F3_HU:   bad = we | lo[0];
            F3_W:    bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extraction with sign/zero extension and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = lane_byte(word_i, lane_i);
    assign sel_half = lane_half(word_i, lane_i[1]);

    always_comb begin
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data_o = {24'h0, sel_byte};
            F3_H:    load_data_o = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data_o = {16'h0, sel_half};
            default: load_data_o = word_i;
        endcase
    end

    always_comb begin
        store_word_o = word_i;
        case (funct3_i)
            F3_B: begin
                case (lane_i)
                    2'd0:    store_word_o[7:0]   = store_data_i[7:0];
                    2'd1:    store_word_o[15:8]  = store_data_i[7:0];
                    2'd2:    store_word_o[23:16] = store_data_i[7:0];
                    default: store_word_o[31:24] = store_data_i[7:0];
                endcase
            end
            F3_H: begin
                if (lane_i[1]) store_word_o[31:16] = store_data_i[15:0];
                else           store_word_o[15:0]  = store_data_i[15:0];
            end
            default: store_word_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory; sub-word stores use read-modify-write.
//  state | meaning
//  IDLE  | ready for a request
//  RD    | memory read of the addressed word
//  WR    | single-cycle memory write
//  RESP  | one-cycle response pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_word_q, wr_word_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [31:0]       load_word, merged_word;

    lsu_align u_align (
        .funct3_i     (f3_q),
        .lane_i       (lane_q),
        .word_i       (read_data),
        .store_data_i (wdata_q),
        .load_data_o  (load_word),
        .store_word_o (merged_word)
    );

    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_q;
    // Memory-side outputs come straight from flops so they never glitch within a cycle.
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign addr       = addr_q;
    assign write_data = wr_word_q;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        f3_d         = f3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        addr_d       = addr_q;
        wr_word_d    = wr_word_q;
        rdata_d      = rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (req_bad(req_we, req_funct3, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (req_we && req_funct3 == F3_W) begin
                            state_d     = ST_WR;
                            mem_write_d = 1'b1;
                            wr_word_d   = req_wdata;
                        end else begin
                            state_d    = ST_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            ST_RD: begin
                if (we_q) begin
                    state_d     = ST_WR;
                    mem_write_d = 1'b1;
                    wr_word_d   = merged_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    rdata_d      = load_word;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            addr_q       <= '0;
            wr_word_q    <= '0;
            rdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            addr_q       <= addr_d;
            wr_word_q    <= wr_word_d;
            rdata_q      <= rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a 128x32 memory and a behavioural reference.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [8:0]  addr;
    logic [31:0] write_data, read_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    logic [31:0] mem [128];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= i;
        end else if (MemWrite) begin
            mem[addr[8:2]] <= write_data;
        end
    end
    assign read_data = MemRead ? mem[addr[8:2]] : 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int         rd_cycles, wr_cycles, viol;
    logic [8:0] exp_waddr;

    always @(negedge clk) begin
        if (!rst) begin
            if (MemRead)  rd_cycles++;
            if (MemWrite) wr_cycles++;
            if (MemRead && MemWrite) viol++;
            if ((MemRead || MemWrite) && addr !== exp_waddr) viol++;
        end
    end

    logic [31:0] ref_mem [128];
    logic [31:0] exp_rdata;

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [8:0] a);
        logic legal, mis;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (f3 == 3'd1 || f3 == 3'd5) mis = (a % 2) != 0;
        else if (f3 == 3'd2)          mis = (a % 4) != 0;
        else                          mis = 1'b0;
        return !legal || mis;
    endfunction

    function automatic logic [31:0] load_ref(input logic [31:0] w, input logic [2:0] f3, input logic [8:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_ref(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [8:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (f3 == 3'd0) begin
            sh   = 8 * (a % 4);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh   = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        check_val(tag, req_ready, 1'b1);
    endtask

    task automatic wait_resp(input string tag, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_val(tag, seen, 1'b1);
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, output logic [31:0] got_rdata);
        logic err;
        int   lat, lat_exp, idx;
        idx = int'(a / 4);
        err = ref_err(we, f3, a);
        lat_exp = err ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        exp_waddr  = a & 9'h1FC;
        wait_ready("accept_ready");
        rd_cycles = 0;
        wr_cycles = 0;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = 9'($urandom_range(0, 511));
        req_wdata  = $urandom;
        wait_resp("resp_seen", lat);
        if (!err) begin
            if (!we) exp_rdata = load_ref(ref_mem[idx], f3, a);
            else     ref_mem[idx] = store_ref(ref_mem[idx], f3, a, wd);
        end
        check_val("latency", lat, lat_exp);
        check_val("resp_err", resp_err, err);
        check_val("resp_rdata", resp_rdata, exp_rdata);
        check_val("memread_cycles", rd_cycles, (!err && (!we || f3 != 3'd2)) ? 1 : 0);
        check_val("memwrite_cycles", wr_cycles, (!err && we) ? 1 : 0);
        got_rdata = resp_rdata;
        @(negedge clk);
        check_val("resp_pulse", resp_valid, 1'b0);
        check_val("ready_after", req_ready, 1'b1);
        check_val("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, wd;
        int          lat, bad;
        rst        = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 9'd0;
        req_wdata  = 32'd0;
        exp_waddr  = 9'd0;
        exp_rdata  = 32'd0;
        rd_cycles  = 0;
        wr_cycles  = 0;
        viol       = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = i;
        repeat (2) @(negedge clk);
        check_val("rst_ready", req_ready, 1'b0);
        check_val("rst_resp_valid", resp_valid, 1'b0);
        check_val("rst_resp_err", resp_err, 1'b0);
        check_val("rst_memread", MemRead, 1'b0);
        check_val("rst_memwrite", MemWrite, 1'b0);
        check_val("rst_rdata", resp_rdata, 32'h0);
        check_val("rst_addr", addr, 9'h0);
        check_val("rst_wdata", write_data, 32'h0);
        preload = 1'b0;
        rst     = 1'b0;

        do_op(1'b0, 3'd2, 9'h010, 32'h0, r);          check_val("lw_010", r, 32'h0000_0004);
        do_op(1'b1, 3'd0, 9'h011, 32'h1234_56AB, r);  check_val("sb_mem4", mem[4], 32'h0000_AB04);
        do_op(1'b0, 3'd0, 9'h011, 32'h0, r);          check_val("lb_011", r, 32'hFFFF_FFAB);
        do_op(1'b0, 3'd4, 9'h011, 32'h0, r);          check_val("lbu_011", r, 32'h0000_00AB);
        do_op(1'b1, 3'd1, 9'h00E, 32'h0000_8001, r);  check_val("sh_mem3", mem[3], 32'h8001_0003);
        do_op(1'b0, 3'd1, 9'h00E, 32'h0, r);          check_val("lh_00e", r, 32'hFFFF_8001);
        do_op(1'b0, 3'd5, 9'h00E, 32'h0, r);          check_val("lhu_00e", r, 32'h0000_8001);
        do_op(1'b0, 3'd2, 9'h006, 32'h0, r);
        do_op(1'b1, 3'd1, 9'h021, 32'hFFFF_FFFF, r);  check_val("err_mem8", mem[8], 32'h0000_0008);

        // Reset during the read phase of a byte store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 9'h021; req_wdata = 32'h5A;
        exp_waddr = 9'h020;
        wait_ready("rmw_ready");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_val("rmw_in_rd", MemRead, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_val("rmw_rst_memread", MemRead, 1'b0);
        check_val("rmw_rst_ready", req_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("rmw_rst_no_resp", resp_valid, 1'b0);
            check_val("rmw_rst_no_write", MemWrite, 1'b0);
        end
        rst = 1'b0;
        exp_rdata = 32'h0;
        @(negedge clk);
        check_val("rmw_rst_idle", req_ready, 1'b1);
        check_val("rmw_rst_mem8", mem[8], 32'h0000_0008);
        check_val("rmw_rst_rdata", resp_rdata, 32'h0);

        // Reset during the write cycle of a word store: MemWrite must fall without a clock.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h080; req_wdata = 32'hDEAD_BEEF;
        exp_waddr = 9'h080;
        wait_ready("sw_rst_ready");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_val("sw_in_wr", MemWrite, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_val("sw_rst_async_drop", MemWrite, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("sw_rst_mem32", mem[32], 32'h0000_0020);

        // Back-to-back with req_valid held: SW then LW to the same word.
        wd = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h040; req_wdata = wd;
        exp_waddr = 9'h040;
        wait_ready("b2b_ready1");
        rd_cycles = 0;
        wr_cycles = 0;
        @(posedge clk);
        #1;
        req_we = 1'b0;
        wait_resp("b2b_resp1", lat);
        check_val("b2b_lat1", lat, 2);
        check_val("b2b_not_ready_in_resp", req_ready, 1'b0);
        ref_mem[16] = wd;
        @(negedge clk);
        check_val("b2b_ready2", req_ready, 1'b1);
        check_val("b2b_wr_cycles", wr_cycles, 1);
        rd_cycles = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp("b2b_resp2", lat);
        check_val("b2b_lat2", lat, 2);
        check_val("b2b_rdata", resp_rdata, wd);
        check_val("b2b_rd_cycles", rd_cycles, 1);
        exp_rdata = wd;
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            logic [8:0] a;
            a = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, r);
        end

        check_val("bus_violations", viol, 0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
        check_val("final_mem", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
